// File: rtl/cube_raster.sv
// Isometric cube rasteriser: top rhombus (4 quadrants) plus left/right side faces, evaluated
// against the pixel counters through a two-stage pipeline, with a visit-level tracker for
// Q*bert landings. Cube offsets are sampled only on frame_start so a moving cube never tears.
module cube_raster #(
  parameter int unsigned XW           = 11,
  parameter int unsigned YW           = 10,
  parameter int unsigned XLEN         = 120,
  parameter int unsigned XDIAG        = 50,
  parameter int unsigned YDIAG        = 90,
  parameter int unsigned NUM_LEVELS   = 2,
  parameter int unsigned TARGET_LEVEL = 1,
  parameter int unsigned WRAP         = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic [XW-1:0]                 x_cnt,
  input  logic [YW-1:0]                 y_cnt,
  input  logic [XW-1:0]                 x_offset,
  input  logic [YW-1:0]                 y_offset,
  input  logic                          qbert_valid,
  input  logic                          qbert_on_top,
  input  logic                          level_clear,
  output logic [3:0]                    top_face,
  output logic                          left_face,
  output logic                          right_face,
  output logic                          passage_qbert,
  output logic [$clog2(NUM_LEVELS)-1:0] level,
  output logic                          completed
);

  localparam int unsigned W  = XW + YW + 8;
  localparam int unsigned LW = $clog2(NUM_LEVELS);

  localparam logic signed [W-1:0] XdiagS  = W'(XDIAG);
  localparam logic signed [W-1:0] YdiagS  = W'(YDIAG);
  localparam logic signed [W-1:0] Ydiag2S = W'(2 * YDIAG);
  localparam logic signed [W-1:0] XlenS   = W'(XLEN);
  localparam logic [LW-1:0]       LvlMax  = LW'(NUM_LEVELS - 1);
  localparam logic [LW-1:0]       LvlTgt  = LW'(TARGET_LEVEL);

  typedef enum logic {StIdle, StOnCube} state_e;

  logic [XW-1:0]         xo_q;
  logic [YW-1:0]         yo_q;
  logic signed [W-1:0]   dx_d, dx_q, d_d, d_q, dy;
  logic                  upper_d, upper_q, lower_d, lower_q;
  logic signed [W-1:0]   adx, rhs, lhs_top, lhs_in, lhs_out;
  logic                  top_hit, side_hit;
  logic [3:0]            top_d, top_q;
  logic                  left_d, left_q, right_d, right_q;
  state_e                state_d, state_q;
  logic [LW-1:0]         level_d, level_q;
  logic                  pulse_d, pulse_q;

  // Stage 1: offset subtraction and half selection (d measured from the nearer y vertex).
  always_comb begin
    dx_d    = $signed(W'(x_cnt)) - $signed(W'(xo_q));
    dy      = $signed(W'(y_cnt)) - $signed(W'(yo_q));
    upper_d = !dy[W-1] && (dy < YdiagS);
    lower_d = (dy >= YdiagS) && (dy <= Ydiag2S);
    d_d     = upper_d ? dy : (Ydiag2S - dy);
  end

  // Stage 2: constant multiplies and edge compares against the rhombus slope.
  always_comb begin
    adx      = dx_q[W-1] ? -dx_q : dx_q;
    rhs      = d_q * XdiagS;
    lhs_top  = adx * YdiagS;
    lhs_in   = dx_q * YdiagS;
    lhs_out  = (dx_q - XlenS) * YdiagS;
    top_hit  = lhs_top <= rhs;
    side_hit = (lhs_in > rhs) && (lhs_out <= rhs);
    top_d    = {lower_q & top_hit & dx_q[W-1],  lower_q & top_hit & !dx_q[W-1],
                upper_q & top_hit & dx_q[W-1],  upper_q & top_hit & !dx_q[W-1]};
    right_d  = upper_q & side_hit;
    left_d   = lower_q & side_hit;
  end

  // Offset latch and both pipeline stages; reset discards everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xo_q    <= '0;
      yo_q    <= '0;
      dx_q    <= '0;
      d_q     <= '0;
      upper_q <= 1'b0;
      lower_q <= 1'b0;
      top_q   <= '0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      if (frame_start) begin
        xo_q <= x_offset;
        yo_q <= y_offset;
      end
      dx_q    <= dx_d;
      d_q     <= d_d;
      upper_q <= upper_d;
      lower_q <= lower_d;
      top_q   <= top_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  // Visit FSM next state; level_clear wins over a simultaneous landing.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    pulse_d = 1'b0;
    if (level_clear) begin
      state_d = StIdle;
      level_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (qbert_valid && qbert_on_top) begin
            state_d = StOnCube;
            pulse_d = 1'b1;
            if (level_q < LvlMax) level_d = level_q + 1'b1;
            else if (WRAP != 0)   level_d = '0;
          end
        end
        StOnCube: begin
          if (!qbert_on_top) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Visit FSM state, level and landing pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      level_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // Output mapping.
  always_comb begin
    top_face      = top_q;
    left_face     = left_q;
    right_face    = right_q;
    passage_qbert = pulse_q;
    level         = level_q;
    completed     = (level_q == LvlTgt);
  end

endmodule

// File: tb/tb_cube_raster.sv
// Self-checking bench for cube_raster: directed points from the test plan plus random
// pixels/offsets/landings, checked against a geometric and behavioural reference model.
module tb_cube_raster;

  localparam int XD = 50;
  localparam int YD = 90;
  localparam int XL = 120;
  localparam int NL = 2;
  localparam int TL = 1;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic [10:0] x_cnt, x_offset;
  logic [9:0]  y_cnt, y_offset;
  logic        qbert_valid, qbert_on_top, level_clear;

  logic [3:0]  top_face, top_face_w;
  logic        left_face, right_face, left_face_w, right_face_w;
  logic        passage_qbert, passage_qbert_w;
  logic [0:0]  level, level_w;
  logic        completed, completed_w;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state.
  int         xo_m, yo_m;
  logic [5:0] pipe[$];
  bit         on_m[2];
  int         lvl_m[2];
  bit         pulse_m[2];

  cube_raster #(.WRAP(0)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .x_offset(x_offset), .y_offset(y_offset),
    .qbert_valid(qbert_valid), .qbert_on_top(qbert_on_top), .level_clear(level_clear),
    .top_face(top_face), .left_face(left_face), .right_face(right_face),
    .passage_qbert(passage_qbert), .level(level), .completed(completed)
  );

  cube_raster #(.WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .x_offset(x_offset), .y_offset(y_offset),
    .qbert_valid(qbert_valid), .qbert_on_top(qbert_on_top), .level_clear(level_clear),
    .top_face(top_face_w), .left_face(left_face_w), .right_face(right_face_w),
    .passage_qbert(passage_qbert_w), .level(level_w), .completed(completed_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected {right, left, top[3:0]}: top = inside the rhombus |dx|/XD + |dy-YD|/YD <= 1;
  // side = right of the rhombus edge but not past that edge shifted by XL.
  function automatic logic [5:0] ref_face(input int x, input int y, input int xo, input int yo);
    int dx, dy, d;
    bit upper, top, side;
    dx = x - xo;
    dy = y - yo;
    if (dy < 0 || dy > 2 * YD) return 6'd0;
    upper = dy < YD;
    d     = YD - iabs(dy - YD);
    top   = iabs(dx) * YD + iabs(dy - YD) * XD <= XD * YD;
    side  = (dx * YD > d * XD) && ((dx - XL) * YD <= d * XD);
    if (top) begin
      if (upper) return (dx >= 0) ? 6'b000001 : 6'b000010;
      else       return (dx >= 0) ? 6'b000100 : 6'b001000;
    end
    if (side) return upper ? 6'b100000 : 6'b010000;
    return 6'd0;
  endfunction

  task automatic model_reset();
    xo_m = 0;
    yo_m = 0;
    pipe.delete();
    for (int i = 0; i < 2; i++) begin
      on_m[i] = 0; lvl_m[i] = 0; pulse_m[i] = 0;
    end
  endtask

  // One clock: predict from the currently driven inputs, advance, then compare.
  task automatic step();
    pipe.push_back(ref_face(int'(x_cnt), int'(y_cnt), xo_m, yo_m));
    if (frame_start) begin
      xo_m = int'(x_offset);
      yo_m = int'(y_offset);
    end
    for (int i = 0; i < 2; i++) begin
      pulse_m[i] = 0;
      if (level_clear) begin
        on_m[i] = 0; lvl_m[i] = 0;
      end else if (!on_m[i] && qbert_valid && qbert_on_top) begin
        on_m[i] = 1; pulse_m[i] = 1;
        if (lvl_m[i] < NL - 1) lvl_m[i] = lvl_m[i] + 1;
        else if (i == 1)       lvl_m[i] = 0;
      end else if (on_m[i] && !qbert_on_top) begin
        on_m[i] = 0;
      end
    end
    @(posedge clk);
    #1;
    if (pipe.size() >= 2) begin
      check_eq("faces", {26'd0, right_face, left_face, top_face}, {26'd0, pipe[pipe.size() - 2]});
      if (pipe.size() > 2) void'(pipe.pop_front());
    end
    check_eq("pulse",       {31'd0, passage_qbert},   {31'd0, pulse_m[0]});
    check_eq("level",       {31'd0, level},           lvl_m[0]);
    check_eq("completed",   {31'd0, completed},       {31'd0, lvl_m[0] == TL});
    check_eq("pulse_wrap",  {31'd0, passage_qbert_w}, {31'd0, pulse_m[1]});
    check_eq("level_wrap",  {31'd0, level_w},         lvl_m[1]);
  endtask

  task automatic pix(input int x, input int y);
    x_cnt = 11'(x);
    y_cnt = 10'(y);
    step();
  endtask

  task automatic new_frame(input int xo, input int yo);
    x_offset    = 11'(xo);
    y_offset    = 10'(yo);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {26'd0, passage_qbert, level, right_face, left_face, top_face}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    frame_start = 1'b0;
    x_cnt = '0; y_cnt = '0; x_offset = '0; y_offset = '0;
    qbert_valid = 1'b0; qbert_on_top = 1'b0; level_clear = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset_state");
    check_eq("reset_completed", {31'd0, completed}, 32'd0);
    #6 reset = 1'b1;

    // Face map around a cube at (200,100).
    new_frame(200, 100);
    pix(200, 100); pix(200, 190); pix(199, 150); pix(300, 150);
    pix(300, 230); pix(200, 291); pix(200, 100); pix(0, 0);
    // Edge exactness on the d=45 row.
    for (int x = 170; x <= 350; x++) pix(x, 145);
    pix(200, 190); pix(200, 189); pix(200, 280); pix(200, 281);

    // Mid-frame offset change is ignored until the next frame_start.
    x_offset = 11'd400;
    pix(200, 100); pix(200, 100);
    new_frame(400, 100);
    pix(200, 100); pix(400, 100); pix(400, 100); pix(0, 0);

    // Landings: first lands, hold, leave, land again.
    qbert_valid = 1'b1; qbert_on_top = 1'b1;
    for (int i = 0; i < 11; i++) pix(400, 100);
    qbert_on_top = 1'b0; pix(400, 100); pix(400, 100);
    qbert_on_top = 1'b1; pix(400, 100); pix(400, 100);
    qbert_on_top = 1'b0; pix(400, 100);

    // level_clear beats a simultaneous landing; landing follows on the next cycle.
    qbert_on_top = 1'b1; level_clear = 1'b1; pix(400, 100);
    level_clear = 1'b0; pix(400, 100); pix(400, 100);
    level_clear = 1'b1; pix(400, 100);
    level_clear = 1'b0; pix(401, 101); pix(402, 102);

    // Asynchronous reset between edges while on the cube with faces active.
    #3 reset = 1'b0;
    #1 check_all_zero("async_reset");
    check_eq("async_reset_wrap", {29'd0, passage_qbert_w, level_w, completed_w}, 32'd0);
    #2 reset = 1'b1;
    model_reset();
    pix(0, 0); pix(10, 5); pix(0, 0);

    // Random frames, pixels and Q*bert behaviour.
    qbert_on_top = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      int xo, yo, xl, yl;
      if (n % 300 == 0) begin
        xo = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 49) : $urandom_range(0, 400);
        yo = $urandom_range(0, 200);
        x_offset = 11'(xo);
        y_offset = 10'(yo);
        frame_start = 1'b1;
      end else begin
        frame_start = ($urandom_range(0, 63) == 0);
        if (frame_start) begin
          x_offset = 11'($urandom_range(0, 400));
          y_offset = 10'($urandom_range(0, 200));
        end
      end
      xl = (xo_m > 80) ? xo_m - 80 : 0;
      yl = (yo_m > 10) ? yo_m - 10 : 0;
      x_cnt = 11'($urandom_range(xo_m + 260, xl));
      y_cnt = 10'($urandom_range(yo_m + 200, yl));
      qbert_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) qbert_on_top = ~qbert_on_top;
      level_clear = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
